// File: rtl/branch_predictor_bht.sv
// Purpose: bimodal/gshare BHT of saturating counters plus a tagged BTB, with a multi-cycle table clear.
// Latency: predictions are combinational (zero cycles); feedback takes effect on the next cycle.
// Backpressure: none; while busy, predictions read as not-taken/miss and feedback is dropped.
module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 10,
    parameter int GSHARE  = 0,
    parameter int GHR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      pred_pc,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [63:0]      pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             fb_valid,
    input  logic [63:0]      fb_pc,
    input  logic             fb_taken,
    input  logic [63:0]      fb_target,
    input  logic [GHR_W-1:0] fb_ghr,
    input  logic             flush,
    output logic             busy
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LO  = IDX_W + 2;
    localparam int TAG_HI  = IDX_W + TAG_W + 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Table storage: counters and BTB valid bits are reset/cleared, tag and
    // target are only meaningful behind a set valid bit so they carry no reset.
    logic [CNT_W-1:0] r_cnt     [ENTRIES];
    logic [ENTRIES-1:0] r_btb_vld;
    logic [TAG_W-1:0] r_btb_tag [ENTRIES];
    logic [63:0]      r_btb_tgt [ENTRIES];
    logic [GHR_W-1:0] r_ghr;

    state_t           r_state;
    logic [IDX_W-1:0] r_clr_idx;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_clr_idx_nxt;
    logic             w_busy;
    logic             w_clr_done;

    logic [IDX_W-1:0] w_pred_pidx;
    logic [TAG_W-1:0] w_pred_tag;
    logic [IDX_W-1:0] w_pred_bidx;
    logic [IDX_W-1:0] w_fb_pidx;
    logic [TAG_W-1:0] w_fb_tag;
    logic [IDX_W-1:0] w_fb_bidx;
    logic             w_update;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hit;
    logic             w_unused;

    // Index/tag extraction. The GHR is cast to the index width: zero-extended
    // when narrower, and only its youngest IDX_W bits fold in when wider.
    assign w_pred_pidx = pred_pc[IDX_W+1:2];
    assign w_pred_tag  = pred_pc[TAG_HI:TAG_LO];
    assign w_fb_pidx   = fb_pc[IDX_W+1:2];
    assign w_fb_tag    = fb_pc[TAG_HI:TAG_LO];
    assign w_pred_bidx = (GSHARE != 0) ? (w_pred_pidx ^ IDX_W'(r_ghr)) : w_pred_pidx;
    assign w_fb_bidx   = (GSHARE != 0) ? (w_fb_pidx ^ IDX_W'(fb_ghr)) : w_fb_pidx;

    // PC bits outside index/tag, and fb_ghr in bimodal mode, do not affect the tables.
    assign w_unused = ^{pred_pc[63:TAG_HI+1], pred_pc[1:0],
                        fb_pc[63:TAG_HI+1], fb_pc[1:0], fb_ghr};

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_update = fb_valid && !w_busy;

    // Saturating counter step for the entry addressed by the feedback.
    always_comb begin
        w_cnt_cur = r_cnt[w_fb_bidx];
        w_cnt_nxt = w_cnt_cur;
        if (fb_taken) begin
            if (w_cnt_cur != CNT_MAX) begin
                w_cnt_nxt = w_cnt_cur + 1'b1;
            end
        end else begin
            if (w_cnt_cur != CNT_MIN) begin
                w_cnt_nxt = w_cnt_cur - 1'b1;
            end
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Clear FSM next state: a flush (re)starts the walk at entry 0; the walk
    // finishes after the last entry unless a flush arrives on that same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (flush) begin
                    w_clr_idx_nxt = '0;
                end else if (r_clr_idx == IDX_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = '0;
                    w_clr_done    = 1'b1;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // Counter table: clear walk has priority; feedback is only seen when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
        end else if (w_busy) begin
            r_cnt[r_clr_idx] <= CNT_INIT;
        end else if (w_update) begin
            r_cnt[w_fb_bidx] <= w_cnt_nxt;
        end
    end

    // BTB valid bits: set by a taken resolution, dropped by reset or the clear walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btb_vld <= '0;
        end else if (w_busy) begin
            r_btb_vld[r_clr_idx] <= 1'b0;
        end else if (w_update && fb_taken) begin
            r_btb_vld[w_fb_pidx] <= 1'b1;
        end
    end

    // BTB payload: tag and target captured alongside the valid bit.
    always_ff @(posedge clk) begin
        if (w_update && fb_taken) begin
            r_btb_tag[w_fb_pidx] <= w_fb_tag;
            r_btb_tgt[w_fb_pidx] <= fb_target;
        end
    end

    // Global history: shifts in resolved outcomes only, zeroed as the clear completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_clr_done) begin
            r_ghr <= '0;
        end else if (w_update) begin
            r_ghr <= GHR_W'({r_ghr, fb_taken});
        end
    end

    // Prediction read-out from pre-update state; suppressed while clearing.
    always_comb begin
        w_hit = !w_busy && r_btb_vld[w_pred_pidx] && (r_btb_tag[w_pred_pidx] == w_pred_tag);
    end

    assign pred_hit    = w_hit;
    assign pred_taken  = w_hit && r_cnt[w_pred_bidx][CNT_W-1];
    assign pred_target = w_hit ? r_btb_tgt[w_pred_pidx] : 64'd0;
    assign pred_ghr    = r_ghr;
    assign busy        = w_busy;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 10;
    localparam int GHR_W   = 8;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CINIT   = (1 << (CNT_W - 1)) - 1;
    localparam int CTHR    = 1 << (CNT_W - 1);

    localparam logic [63:0] PC  = 64'h8000_0010;
    localparam logic [63:0] TGT = 64'h8000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n     = 1'b0;
    logic [63:0]      pred_pc   = PC;
    logic             fb_valid  = 1'b0;
    logic [63:0]      fb_pc     = '0;
    logic             fb_taken  = 1'b0;
    logic [63:0]      fb_target = '0;
    logic [GHR_W-1:0] fb_ghr    = '0;
    logic             flush     = 1'b0;

    // index 0: bimodal instance, index 1: gshare instance
    logic [1:0]       p_taken;
    logic [1:0]       p_hit;
    logic [1:0]       p_busy;
    logic [63:0]      p_tgt [2];
    logic [GHR_W-1:0] p_ghr [2];

    branch_predictor_bht #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W), .GSHARE(0), .GHR_W(GHR_W)) u_bim (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc),
        .pred_taken(p_taken[0]), .pred_hit(p_hit[0]), .pred_target(p_tgt[0]), .pred_ghr(p_ghr[0]),
        .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target), .fb_ghr(fb_ghr),
        .flush(flush), .busy(p_busy[0])
    );

    branch_predictor_bht #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W), .GSHARE(1), .GHR_W(GHR_W)) u_gsh (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc),
        .pred_taken(p_taken[1]), .pred_hit(p_hit[1]), .pred_target(p_tgt[1]), .pred_ghr(p_ghr[1]),
        .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target), .fb_ghr(fb_ghr),
        .flush(flush), .busy(p_busy[1])
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt [2][ENTRIES];
    bit          m_vld [ENTRIES];
    int          m_tag [ENTRIES];
    logic [63:0] m_tgt [ENTRIES];
    int          m_ghr;
    int          m_busy_left;

    function automatic int m_pidx(input logic [63:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    function automatic int m_tagof(input logic [63:0] pc);
        return int'(pc[IDX_W+TAG_W+1:IDX_W+2]);
    endfunction

    function automatic int m_bidx(input int g, input logic [63:0] pc, input int ghr);
        int p;
        p = m_pidx(pc);
        if (g == 1) p = (p ^ ghr) % ENTRIES;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_cnt[0][i] = CINIT;
                m_cnt[1][i] = CINIT;
                m_vld[i]    = 1'b0;
            end
            m_ghr       = 0;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            // feedback ignored while clearing; a flush restarts the full count
            if (flush) begin
                m_busy_left = ENTRIES;
            end else begin
                m_busy_left = m_busy_left - 1;
                if (m_busy_left == 0) m_ghr = 0;
            end
        end else begin
            if (fb_valid) begin
                for (int g = 0; g < 2; g++) begin
                    int b;
                    int c;
                    b = m_bidx(g, fb_pc, int'(fb_ghr));
                    c = m_cnt[g][b];
                    if (fb_taken) c = (c + 1 > CMAX) ? CMAX : c + 1;
                    else          c = (c - 1 < 0) ? 0 : c - 1;
                    m_cnt[g][b] = c;
                end
                if (fb_taken) begin
                    m_vld[m_pidx(fb_pc)] = 1'b1;
                    m_tag[m_pidx(fb_pc)] = m_tagof(fb_pc);
                    m_tgt[m_pidx(fb_pc)] = fb_target;
                end
                m_ghr = ((m_ghr << 1) | int'(fb_taken)) & ((1 << GHR_W) - 1);
            end
            if (flush) begin
                // the tables end up fully re-initialised; predictions stay masked meanwhile
                for (int i = 0; i < ENTRIES; i++) begin
                    m_cnt[0][i] = CINIT;
                    m_cnt[1][i] = CINIT;
                    m_vld[i]    = 1'b0;
                end
                m_busy_left = ENTRIES;
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int g = 0; g < 2; g++) begin
                string pfx;
                int    p;
                bit    e_hit;
                bit    e_taken;
                logic [63:0] e_tgt;
                pfx     = (g == 1) ? "gsh" : "bim";
                p       = m_pidx(pred_pc);
                e_hit   = (m_busy_left == 0) && m_vld[p] && (m_tag[p] == m_tagof(pred_pc));
                e_taken = e_hit && (m_cnt[g][m_bidx(g, pred_pc, m_ghr)] >= CTHR);
                e_tgt   = e_hit ? m_tgt[p] : 64'd0;
                chk({pfx, "_hit"},    64'(p_hit[g]),   64'(e_hit));
                chk({pfx, "_taken"},  64'(p_taken[g]), 64'(e_taken));
                chk({pfx, "_target"}, p_tgt[g],        e_tgt);
                chk({pfx, "_ghr"},    64'(p_ghr[g]),   64'(m_ghr));
                chk({pfx, "_busy"},   64'(p_busy[g]),  64'(m_busy_left > 0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic fv, input logic [63:0] fpc, input logic ft,
                       input logic [63:0] ftg, input logic fl, input logic [63:0] ppc);
        @(posedge clk);
        #1;
        fb_valid  = fv;
        fb_pc     = fpc;
        fb_taken  = ft;
        fb_target = ftg;
        flush     = fl;
        pred_pc   = ppc;
        fb_ghr    = GHR_W'(m_ghr);
        @(negedge clk);
    endtask

    task automatic idle(input logic [63:0] ppc);
        drv(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, ppc);
    endtask

    // Counts busy cycles following the current one; bounded so a stuck busy ends the run.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == 10) drv(1'b1, 64'h8000_0200, 1'b1, 64'h1234, 1'b0, PC);
            else         idle(PC);
            if (p_busy[0]) n++;
            else break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int         nb;
        logic [15:0] pat;
        logic [63:0] lpc;

        // Test 1: reset values, both while held and after release
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(p_busy[0]), 64'd0);
        chk("rst_ghr",  64'(p_ghr[0]),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(PC);
        chk("t1_taken",  64'(p_taken[0]), 64'd0);
        chk("t1_hit",    64'(p_hit[0]),   64'd0);
        chk("t1_target", p_tgt[0],        64'd0);
        chk("t1_ghr",    64'(p_ghr[0]),   64'd0);
        chk("t1_busy",   64'(p_busy[0]),  64'd0);

        // Test 2: two taken resolutions train 1 -> 3 and fill the BTB
        drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        idle(PC);
        chk("t2_taken",  64'(p_taken[0]), 64'd1);
        chk("t2_hit",    64'(p_hit[0]),   64'd1);
        chk("t2_target", p_tgt[0],        TGT);

        // Test 4: same index, different tag misses
        idle(PC + (64'(ENTRIES) << 2));
        chk("t4_hit",   64'(p_hit[0]),   64'd0);
        chk("t4_taken", 64'(p_taken[0]), 64'd0);

        // Test 3: saturation then two not-taken steps
        repeat (5) drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        drv(1'b1, PC, 1'b0, 64'd0, 1'b0, PC);
        idle(PC);
        chk("t3_taken_after_1nt", 64'(p_taken[0]), 64'd1);
        drv(1'b1, PC, 1'b0, 64'd0, 1'b0, PC);
        idle(PC);
        chk("t3_taken_after_2nt", 64'(p_taken[0]), 64'd0);
        chk("t3_hit_after_2nt",   64'(p_hit[0]),   64'd1);
        // history: seven taken then two not-taken
        chk("t3_ghr", 64'(p_ghr[0]), 64'hFC);

        // Directed mix over a few PCs to exercise gshare indexing
        pat = 16'b1011_0110_1110_0101;
        for (int i = 0; i < 16; i++) begin
            lpc = 64'h8000_1000 + 64'((i % 4) * 4);
            drv(1'b1, lpc, pat[i], 64'h8000_2000 + 64'(i * 16), 1'b0, lpc);
        end
        for (int i = 0; i < 4; i++) idle(64'h8000_1000 + 64'(i * 4));

        // Test 5: flush, busy for exactly ENTRIES cycles, mid-clear feedback dropped
        drv(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, PC);
        count_busy(nb);
        chk("t5_busy_cycles", 64'(nb), 64'(ENTRIES));
        chk("t5_taken", 64'(p_taken[0]), 64'd0);
        chk("t5_hit",   64'(p_hit[0]),   64'd0);
        chk("t5_ghr",   64'(p_ghr[0]),   64'd0);
        idle(64'h8000_0200);
        chk("t5_dropped_fb_hit", 64'(p_hit[0]), 64'd0);

        // Flush again mid-clear restarts the walk
        drv(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, PC);
        repeat (20) idle(PC);
        drv(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, PC);
        count_busy(nb);
        chk("restart_busy_cycles", 64'(nb), 64'(ENTRIES));

        // Reset mid-clear aborts immediately
        drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        drv(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, PC);
        repeat (10) idle(PC);
        chk("midclr_busy", 64'(p_busy[0]), 64'd1);
        chk("midclr_ghr",  64'(p_ghr[0]),  64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(p_busy[0]), 64'd0);
        chk("arst_ghr",  64'(p_ghr[0]),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 6: same-cycle update and predict reads old state
        drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        chk("t6_same_cycle_taken", 64'(p_taken[0]), 64'd0);
        idle(PC);
        chk("t6_next_cycle_taken", 64'(p_taken[0]), 64'd1);
        chk("t6_next_cycle_hit",   64'(p_hit[0]),   64'd1);
        drv(1'b1, PC, 1'b0, 64'd0, 1'b0, PC);
        drv(1'b1, PC, 1'b1, TGT, 1'b0, PC);
        idle(PC);
        chk("t6_gsh_ghr", 64'(p_ghr[1]), 64'h05);

        idle(PC);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
